// File: rtl/hd_mux_pkg.sv
// Shared constants and helpers for the hd_muxn_stream family of streaming
// multiplexers.
package hd_mux_pkg;

    // Selection modes: select-driven or round-robin arbitration
    localparam int HD_MUX_MODE_SEL = 32'd0;
    localparam int HD_MUX_MODE_RR  = 32'd1;

    // Width of a channel index for n channels; never narrower than one bit
    function automatic int hd_sel_w(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : hd_mux_pkg

// File: rtl/hd_rr_pick.sv
// Rotating-priority first-one finder: returns the first asserted request
// found when scanning from ptr upward with wrap-around.
module hd_rr_pick
    import hd_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = hd_sel_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [SEL_W-1:0] gnt_idx_s;
    logic             gnt_any_s;
    int               base_s;
    int               idx_s;
    logic             hit_s;

    // Scan all channels starting at ptr; the first request seen wins
    always_comb begin
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        idx_s     = 32'sd0;
        hit_s     = 1'b0;
        // A pointer outside the channel range is treated as channel 0
        base_s    = (int'(ptr) < NUM_IN) ? int'(ptr) : 32'sd0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx_s     = base_s + k;
            idx_s     = (idx_s >= NUM_IN) ? (idx_s - NUM_IN) : idx_s;
            hit_s     = req[idx_s] & ~gnt_any_s;
            gnt_idx_s = hit_s ? SEL_W'(idx_s) : gnt_idx_s;
            gnt_any_s = gnt_any_s | hit_s;
        end
    end

    assign gnt_idx = gnt_idx_s;
    assign gnt_any = gnt_any_s;

endmodule : hd_rr_pick

// File: rtl/hd_muxn_stream.sv
// N-input streaming multiplexer with per-channel valid/ready, one registered
// output stage with backpressure, and either external-select or round-robin
// channel selection.
module hd_muxn_stream
    import hd_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 8,
    parameter int MODE   = HD_MUX_MODE_SEL,
    parameter int SEL_W  = hd_sel_w(NUM_IN)
) (
    input  logic                    CK,
    input  logic                    RN,
    input  logic [NUM_IN*WIDTH-1:0] A,
    input  logic [NUM_IN-1:0]       AV,
    output logic [NUM_IN-1:0]       AR,
    input  logic [SEL_W-1:0]        SL,
    output logic [WIDTH-1:0]        Z,
    output logic                    ZV,
    input  logic                    ZR,
    output logic [SEL_W-1:0]        ZSEL
);

    // Output stage and round-robin pointer
    logic [WIDTH-1:0]  z_r;
    logic              zv_r;
    logic [SEL_W-1:0]  zsel_r;
    logic [SEL_W-1:0]  ptr_r;

    // Combinational selection path
    logic              load_s;
    logic              sel_hit_s;
    logic [SEL_W-1:0]  rr_idx_s;
    logic              rr_any_s;
    logic [SEL_W-1:0]  gnt_idx_s;
    logic              gnt_any_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  gnt_data_s;
    logic [NUM_IN-1:0] ar_s;
    logic [SEL_W-1:0]  ptr_nxt_s;

    // The output register may take a new beat when empty or being drained
    assign load_s = ~zv_r | ZR;
    assign xfer_s = load_s & gnt_any_s;

    hd_rr_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req     (AV),
        .ptr     (ptr_r),
        .gnt_idx (rr_idx_s),
        .gnt_any (rr_any_s)
    );

    // Select-mode hit: SL names an in-range channel that is valid. An unknown
    // SL makes the equality unknown, which falls into the else branch, so an
    // X select can never produce a grant.
    always_comb begin
        sel_hit_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if ((SL == SEL_W'(i)) && (AV[i] == 1'b1)) begin
                sel_hit_s = 1'b1;
            end else begin
                sel_hit_s = sel_hit_s;
            end
        end
    end

    // Mode muxing: pick the grant source; index is forced to 0 without a grant
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = '0;
        if (MODE == HD_MUX_MODE_RR) begin
            gnt_any_s = rr_any_s;
            gnt_idx_s = rr_any_s ? rr_idx_s : '0;
        end else begin
            if (sel_hit_s) begin
                gnt_any_s = 1'b1;
                gnt_idx_s = SL;
            end else begin
                gnt_any_s = 1'b0;
                gnt_idx_s = '0;
            end
        end
    end

    // Data mux over the packed channel bus, indexed by the granted channel
    always_comb begin
        gnt_data_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx_s == SEL_W'(i)) begin
                gnt_data_s = A[i*WIDTH +: WIDTH];
            end else begin
                gnt_data_s = gnt_data_s;
            end
        end
    end

    // One-hot ready back to the granted producer; all low while in reset
    always_comb begin
        ar_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            ar_s[i] = RN & load_s & gnt_any_s & (gnt_idx_s == SEL_W'(i));
        end
    end

    // Round-robin pointer advances past the winner, only on a real transfer
    always_comb begin
        ptr_nxt_s = ptr_r;
        if ((MODE == HD_MUX_MODE_RR) && xfer_s) begin
            ptr_nxt_s = (gnt_idx_s == SEL_W'(NUM_IN - 1)) ? '0 : (gnt_idx_s + SEL_W'(1));
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Output register: load on transfer, empty on idle load, hold on stall
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            z_r    <= '0;
            zv_r   <= 1'b0;
            zsel_r <= '0;
            ptr_r  <= '0;
        end else if (xfer_s) begin
            z_r    <= gnt_data_s;
            zv_r   <= 1'b1;
            zsel_r <= gnt_idx_s;
            ptr_r  <= ptr_nxt_s;
        end else if (load_s) begin
            zv_r   <= 1'b0;
        end
    end

    assign AR   = ar_s;
    assign Z    = z_r;
    assign ZV   = zv_r;
    assign ZSEL = zsel_r;

endmodule : hd_muxn_stream

// File: tb/tb_hd_muxn_stream.sv
// Scoreboard bench for hd_muxn_stream. Three instances run side by side:
// 4-channel select mode, 4-channel round-robin, 3-channel select mode.
module tb_hd_muxn_stream;

    logic        CK;
    logic        RN;
    logic [31:0] a_v   [3];
    logic [3:0]  av_v  [3];
    logic [1:0]  sl_v  [3];
    logic [2:0]  zr_v;

    logic [3:0]  ar0;
    logic [3:0]  ar1;
    logic [2:0]  ar2;
    logic [7:0]  z_w    [3];
    logic [2:0]  zv_w;
    logic [1:0]  zsel_w [3];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         NN [3] = '{4, 4, 3};
    int         MD [3] = '{0, 1, 0};
    bit         mdl_zv  [3];
    int         mdl_ptr [3];
    logic [9:0] sbq [3][$];   // {index, data} of beats expected on Z

    hd_muxn_stream #(.NUM_IN(4), .WIDTH(8), .MODE(0)) u_sel4 (
        .CK(CK), .RN(RN), .A(a_v[0]), .AV(av_v[0]), .AR(ar0), .SL(sl_v[0]),
        .Z(z_w[0]), .ZV(zv_w[0]), .ZR(zr_v[0]), .ZSEL(zsel_w[0]));

    hd_muxn_stream #(.NUM_IN(4), .WIDTH(8), .MODE(1)) u_rr4 (
        .CK(CK), .RN(RN), .A(a_v[1]), .AV(av_v[1]), .AR(ar1), .SL(sl_v[1]),
        .Z(z_w[1]), .ZV(zv_w[1]), .ZR(zr_v[1]), .ZSEL(zsel_w[1]));

    hd_muxn_stream #(.NUM_IN(3), .WIDTH(8), .MODE(0)) u_sel3 (
        .CK(CK), .RN(RN), .A(a_v[2][23:0]), .AV(av_v[2][2:0]), .AR(ar2), .SL(sl_v[2]),
        .Z(z_w[2]), .ZV(zv_w[2]), .ZR(zr_v[2]), .ZSEL(zsel_w[2]));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic logic [3:0] ar_of(input int d);
        if (d == 0) return ar0;
        else if (d == 1) return ar1;
        else return {1'b0, ar2};
    endfunction

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %h expected %h", d, nm, act, exp);
        end
    endtask

    // Apply current inputs, predict ready and the next output from the rules,
    // then advance one clock (returns just after the rising edge).
    task automatic step();
        int   n;
        int   g;
        bit   has;
        bit   load;
        logic [3:0] exp_ar;
        av_v[2][3] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n = NN[d];
            chk(d, "zv", zv_w[d], mdl_zv[d]);
            load = !mdl_zv[d] || zr_v[d];
            has = 0;
            g = 0;
            if (MD[d] == 0) begin
                if (int'(sl_v[d]) < n && av_v[d][sl_v[d]]) begin
                    has = 1;
                    g = int'(sl_v[d]);
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (!has && av_v[d][(mdl_ptr[d] + k) % n]) begin
                        has = 1;
                        g = (mdl_ptr[d] + k) % n;
                    end
                end
            end
            exp_ar = (load && has) ? (4'b0001 << g) : 4'b0000;
            chk(d, "ar", ar_of(d), exp_ar);
            if (load && has) begin
                sbq[d].push_back({g[1:0], a_v[d][g*8 +: 8]});
                mdl_zv[d] = 1;
                if (MD[d] == 1) mdl_ptr[d] = (g + 1) % n;
            end else if (load) begin
                mdl_zv[d] = 0;
            end
        end
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        for (int d = 0; d < 3; d++) begin
            av_v[d] = 4'hF;
            zr_v[d] = 1'b1;
        end
        RN = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk(d, "rst_z", z_w[d], 0);
            chk(d, "rst_zv", zv_w[d], 0);
            chk(d, "rst_zsel", zsel_w[d], 0);
            chk(d, "rst_ar", ar_of(d), 0);
            sbq[d].delete();
            mdl_zv[d]  = 0;
            mdl_ptr[d] = 0;
        end
        @(posedge CK);
        @(posedge CK);
        #1;
        RN = 1'b1;
    endtask

    // Monitor: whenever a beat is presented, it must match the oldest
    // expected beat; it is retired when downstream accepts it.
    always @(negedge CK) begin
        if (RN === 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                if (zv_w[d] === 1'b1) begin
                    chk(d, "zv_has_beat", zv_w[d], (sbq[d].size() != 0) ? 1 : 0);
                    if (sbq[d].size() != 0) begin
                        chk(d, "z", z_w[d], sbq[d][0][7:0]);
                        chk(d, "zsel", zsel_w[d], sbq[d][0][9:8]);
                        if (zr_v[d]) void'(sbq[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int hist [4];
        RN = 1'b1;
        for (int d = 0; d < 3; d++) begin
            a_v[d]  = 32'h0;
            av_v[d] = 4'hF;
            sl_v[d] = 2'd0;
        end
        zr_v = 3'b111;
        #2;
        do_reset();

        // Reset release, select, round-robin fairness
        a_v[0]  = 32'h44332211;
        a_v[1]  = 32'hD4C3B2A1;
        a_v[2]  = 32'h00CCBBAA;
        sl_v[0] = 2'd2;
        sl_v[2] = 2'd1;
        #1;
        chk(0, "first_ar_sel", ar0, 4'b0100);
        chk(1, "first_ar_rr", ar1, 4'b0001);
        for (int i = 0; i < 4; i++) hist[i] = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk(1, "rr_seq", zsel_w[1], k % 4);
            hist[zsel_w[1]]++;
            if (k == 0) begin
                chk(0, "sel2_z", z_w[0], 8'h33);
                chk(0, "sel2_zv", zv_w[0], 1);
                chk(0, "sel2_zsel", zsel_w[0], 2);
                sl_v[0] = 2'd0;
            end
            if (k == 1) chk(0, "sel0_z", z_w[0], 8'h11);
        end
        for (int i = 0; i < 4; i++) chk(1, "rr_fair", hist[i], 2);

        // Backpressure on u_sel4, wrap/skip on u_rr4
        zr_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_v[0]  = $urandom;
            sl_v[0] = 2'($urandom_range(0, 3));
            av_v[1] = (k == 0) ? 4'b0010 : ((k == 1) ? 4'b0001 : 4'b1111);
            step();
            chk(0, "bp_z", z_w[0], 8'h11);
            chk(0, "bp_zsel", zsel_w[0], 0);
            chk(0, "bp_zv", zv_w[0], 1);
            chk(1, "rr_skip", zsel_w[1], (k == 0) ? 1 : ((k == 1) ? 0 : 1));
        end
        zr_v[0] = 1'b1;
        sl_v[0] = 2'd3;
        a_v[0]  = 32'hDDCCBBAA;
        step();
        chk(0, "bp_release_z", z_w[0], 8'hDD);
        chk(0, "bp_release_zsel", zsel_w[0], 3);

        // Out-of-range and unknown select on the 3-channel instance
        av_v[2] = 4'b0111;
        sl_v[2] = 2'd1;
        zr_v[2] = 1'b0;
        step();
        sl_v[2] = 2'd3;
        step();
        zr_v[2] = 1'b1;
        #1;
        chk(2, "oor_ar", ar2, 3'b000);
        step();
        chk(2, "oor_zv", zv_w[2], 0);
        sl_v[2] = 2'bxx;
        #1;
        chk(2, "x_sel_ar_known", $isunknown(ar2), 0);
        chk(2, "x_sel_zv_known", $isunknown(zv_w[2]), 0);
        sl_v[2] = 2'd0;

        // Randomized traffic with a reset in the middle
        for (int k = 0; k < 500; k++) begin
            if (k == 250) do_reset();
            for (int d = 0; d < 3; d++) begin
                a_v[d]  = $urandom;
                av_v[d] = 4'($urandom_range(0, 15));
                sl_v[d] = 2'($urandom_range(0, 3));
                zr_v[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        // Drain
        for (int d = 0; d < 3; d++) begin
            av_v[d] = 4'h0;
            zr_v[d] = 1'b1;
        end
        for (int k = 0; k < 3; k++) step();
        @(negedge CK);
        #1;
        for (int d = 0; d < 3; d++) chk(d, "drain_empty", sbq[d].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hd_muxn_stream
